// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter that shares one I2C master between
// NREQ requesters. Each grant carries a single byte transaction (direction,
// 7-bit slave address, write byte). The block launches it on the master and
// waits for completion or a bounded timeout. It then hands status and read
// data back to the granted requester with a one-cycle done pulse.
module i2c_txn_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [8*NREQ-1:0]    req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 nack,
    output logic                 timeout,
    output logic [7:0]           rdata,
    output logic                 m_start,
    output logic                 m_rw,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_data,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_nack,
    input  logic [7:0]           m_rdata
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e             state_q;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      idx_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic [NREQ-1:0]    gnt_q;
    logic [NREQ-1:0]    done_q;
    logic               nack_q;
    logic               timeout_q;
    logic [7:0]         rdata_q;
    logic               m_start_q;
    logic               m_rw_q;
    logic [6:0]         m_addr_q;
    logic [7:0]         m_data_q;

    logic [IW:0]        pick_d;
    logic               pick_valid_d;
    logic [IW-1:0]      pick_idx_d;

    // First set request at or above the pointer, wrapping; returns {valid, index}.
    // Candidates are visited from farthest to nearest so the nearest one wins.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   p);
        logic [IW:0] res;
        int          cand;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(p) + k) % NREQ;
            if (r[cand]) begin
                res = {1'b1, IW'(cand)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Round-robin candidate selection and the wait-counter increment.
    always_comb begin
        pick_d       = rr_pick(req, ptr_q);
        pick_valid_d = pick_d[IW];
        pick_idx_d   = pick_d[IW-1:0];
        cnt_d        = cnt_q + CW'(1);
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= 8'h00;
            m_start_q <= 1'b0;
            m_rw_q    <= 1'b0;
            m_addr_q  <= 7'h00;
            m_data_q  <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q    <= '0;
                    nack_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    rdata_q   <= 8'h00;
                    m_start_q <= 1'b0;
                    if (pick_valid_d) begin
                        idx_q    <= pick_idx_d;
                        gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_d;
                        m_rw_q   <= req_rw[pick_idx_d];
                        m_addr_q <= req_addr[int'(pick_idx_d)*7 +: 7];
                        m_data_q <= req_wdata[int'(pick_idx_d)*8 +: 8];
                        state_q  <= ST_LAUNCH;
                    end else begin
                        gnt_q    <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    if (!m_busy) begin
                        m_start_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_WAIT;
                    end else begin
                        m_start_q <= 1'b0;
                        state_q   <= ST_LAUNCH;
                    end
                end
                ST_WAIT: begin
                    m_start_q <= 1'b0;
                    cnt_q     <= cnt_d;
                    // A completion in the same cycle as the timeout takes precedence.
                    if (m_done) begin
                        nack_q    <= m_nack;
                        rdata_q   <= m_rw_q ? m_rdata : 8'h00;
                        timeout_q <= 1'b0;
                        done_q    <= gnt_q;
                        state_q   <= ST_RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        nack_q    <= 1'b0;
                        rdata_q   <= 8'h00;
                        timeout_q <= 1'b1;
                        done_q    <= gnt_q;
                        state_q   <= ST_RESP;
                    end else begin
                        state_q   <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    done_q    <= '0;
                    gnt_q     <= '0;
                    nack_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    rdata_q   <= 8'h00;
                    m_start_q <= 1'b0;
                    // The requester just served drops to lowest priority.
                    if (idx_q == IW'(NREQ - 1)) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= idx_q + IW'(1);
                    end
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    gnt_q     <= '0;
                    done_q    <= '0;
                    m_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign nack    = nack_q;
    assign timeout = timeout_q;
    assign rdata   = rdata_q;
    assign m_start = m_start_q;
    assign m_rw    = m_rw_q;
    assign m_addr  = m_addr_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: a behavioural master answers each launch,
// expected grants and responses are queued when stimulus is driven and
// compared when the arbiter produces them.
module tb_i2c_txn_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 100;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_rw;
    logic [7*NREQ-1:0]  req_addr;
    logic [8*NREQ-1:0]  req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               nack;
    logic               timeout;
    logic [7:0]         rdata;
    logic               m_start;
    logic               m_rw;
    logic [6:0]         m_addr;
    logic [7:0]         m_data;
    logic               m_busy;
    logic               m_done;
    logic               m_nack;
    logic [7:0]         m_rdata;

    typedef struct packed {
        logic [NREQ-1:0] done;
        logic            nack;
        logic            tmo;
        logic [7:0]      rdata;
    } resp_t;

    resp_t  sb_q[$];
    int     gnt_q[$];
    int     tests = 0;
    int     fails = 0;

    logic [6:0] addr_tb [NREQ];
    logic [7:0] wd_tb   [NREQ];
    logic       rw_tb   [NREQ];

    i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .nack(nack), .timeout(timeout), .rdata(rdata), .m_start(m_start),
        .m_rw(m_rw), .m_addr(m_addr), .m_data(m_data), .m_busy(m_busy),
        .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_fields();
        for (int i = 0; i < NREQ; i++) begin
            req_rw[i]             = rw_tb[i];
            req_addr[7*i +: 7]    = addr_tb[i];
            req_wdata[8*i +: 8]   = wd_tb[i];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; m_busy = 1'b0; m_done = 1'b0;
        m_nack = 1'b0; m_rdata = 8'h00;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   gnt, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_start"}, m_start, 0);
        chk({tag, "_maddr"}, m_addr, 0);
        chk({tag, "_mdata"}, m_data, 0);
        chk({tag, "_mrw"},   m_rw, 0);
        chk({tag, "_nack"},  nack, 0);
        chk({tag, "_tmo"},   timeout, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    task automatic check_resp(input string tag);
        resp_t e;
        e = sb_q.pop_front();
        chk({tag, "_done"},  done, e.done);
        chk({tag, "_nack"},  nack, e.nack);
        chk({tag, "_tmo"},   timeout, e.tmo);
        chk({tag, "_rdata"}, rdata, e.rdata);
    endtask

    // Wait (bounded) for a launch and check it against the next expected grant.
    task automatic wait_launch(input string tag, output int idx);
        int n = 0;
        while (m_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_start_seen"}, m_start, 1);
        idx = gnt_q.pop_front();
        chk({tag, "_gnt"},   gnt, 1 << idx);
        chk({tag, "_mrw"},   m_rw, rw_tb[idx]);
        chk({tag, "_maddr"}, m_addr, addr_tb[idx]);
        chk({tag, "_mdata"}, m_data, wd_tb[idx]);
    endtask

    // Master answers lat cycles after m_start; done expected the next cycle.
    task automatic run_txn(input string tag, input logic nack_in,
                           input logic [7:0] rd_in, input int lat);
        int    idx;
        resp_t e;
        wait_launch(tag, idx);
        for (int j = 0; j < lat; j++) tick();
        m_done = 1'b1; m_nack = nack_in; m_rdata = rd_in;
        e.done  = NREQ'(1 << idx);
        e.nack  = nack_in;
        e.tmo   = 1'b0;
        e.rdata = rw_tb[idx] ? rd_in : 8'h00;
        sb_q.push_back(e);
        tick();
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        check_resp(tag);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    idx;
        int    early;
        resp_t e;

        addr_tb[0] = 7'h66; wd_tb[0] = 8'hF0; rw_tb[0] = 1'b0;
        addr_tb[1] = 7'h21; wd_tb[1] = 8'h11; rw_tb[1] = 1'b0;
        addr_tb[2] = 7'h32; wd_tb[2] = 8'h22; rw_tb[2] = 1'b1;
        addr_tb[3] = 7'h43; wd_tb[3] = 8'h33; rw_tb[3] = 1'b0;
        req_rw = '0; req_addr = '0; req_wdata = '0;

        // Reset state
        do_reset();
        chk_all_zero("reset");
        apply_fields();

        // 1. Single write with exact latency
        req = 4'b0001;
        tick();
        chk("t1_gnt_c1", gnt, 4'b0001);
        chk("t1_nostart_c1", m_start, 0);
        tick();
        chk("t1_start_c2", m_start, 1);
        gnt_q.push_back(0);
        run_txn("t1", 1'b0, 8'h77, 40);
        req = '0;

        // 2a. Round-robin with all requesting
        do_reset();
        apply_fields();
        req = 4'b1111;
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2);
        gnt_q.push_back(3); gnt_q.push_back(0); gnt_q.push_back(1);
        for (int k = 0; k < 6; k++) run_txn("t2a", 1'b0, 8'(8'h40 + k), 3);
        req = '0;

        // 2b. Round-robin with sparse requests
        do_reset();
        apply_fields();
        req = 4'b1010;
        gnt_q.push_back(1); gnt_q.push_back(3); gnt_q.push_back(1); gnt_q.push_back(3);
        for (int k = 0; k < 4; k++) run_txn("t2b", 1'b0, 8'h00, 2);
        req = '0;

        // 3. Read held off by a busy master
        do_reset();
        apply_fields();
        req = 4'b0100; m_busy = 1'b1;
        tick();
        chk("t3_gnt", gnt, 4'b0100);
        for (int k = 0; k < 5; k++) begin
            chk("t3_busy_nostart", m_start, 0);
            if (k == 4) m_busy = 1'b0;
            if (k < 4) tick();
        end
        tick();
        chk("t3_start_after_busy", m_start, 1);
        gnt_q.push_back(2);
        run_txn("t3", 1'b0, 8'hA5, 5);
        req = '0;

        // 4. NACK on a write
        do_reset();
        apply_fields();
        req = 4'b0001;
        gnt_q.push_back(0);
        run_txn("t4", 1'b1, 8'h5A, 7);
        req = '0;

        // 5. Timeout, then a stray m_done in IDLE
        do_reset();
        apply_fields();
        req = 4'b0010;
        gnt_q.push_back(1);
        wait_launch("t5", idx);
        e.done = 4'b0010; e.nack = 1'b0; e.tmo = 1'b1; e.rdata = 8'h00;
        sb_q.push_back(e);
        early = 0;
        for (int j = 1; j < TMO; j++) begin
            tick();
            if (done !== 4'b0000) early++;
        end
        chk("t5_no_early_done", early, 0);
        tick();
        check_resp("t5");
        req = '0;
        tick();
        m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'hEE;
        tick();
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        chk("t5_idle_mdone_done", done, 0);
        tick();
        chk("t5_idle_mdone_done2", done, 0);
        chk("t5_idle_gnt", gnt, 0);

        // 6. Reset in WAIT aborts silently
        do_reset();
        apply_fields();
        req = 4'b0010;
        gnt_q.push_back(1);
        wait_launch("t6", idx);
        tick(); tick(); tick();
        chk("t6_gnt_wait", gnt, 4'b0010);
        reset = 1'b1; req = 4'b0110;
        tick();
        chk_all_zero("t6_rst");
        reset = 1'b0;
        tick();
        chk("t6_first_gnt", gnt, 4'b0010);
        chk("t6_no_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
